pipe_stage_reg: RTL

//  Parametrised inter-stage pipeline register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_skid_entry.sv | 44 ++++
 rtl/pipe_stage_reg.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage register: occupancy state encoding and default NOP.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_SKID  = 2'd2
  } occ_state_t;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pipe_skid_entry.sv
// One payload entry {pc4, inst} with load, clear and NOP fill; clear wins over load.
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_DEFAULT)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [PC_W-1:0]   i_pc4,
  input  logic [INST_W-1:0] i_inst,
  output logic              o_valid,
  output logic [PC_W-1:0]   o_pc4,
  output logic [INST_W-1:0] o_inst
);

  logic              r_valid;
  logic [PC_W-1:0]   r_pc4;
  logic [INST_W-1:0] r_inst;

  // Clearing keeps pc4 so a squashed stage still shows the last address it held.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_pc4   <= '0;
      r_inst  <= NOP_INST;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc4   <= i_pc4;
      r_inst  <= i_inst;
    end
  end

  assign o_valid = r_valid;
  assign o_pc4   = r_pc4;
  assign o_inst  = r_inst;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional PIPE_STAGE_PERF_EN adds saturating stall_cnt / bubble_cnt outputs.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_DEFAULT)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc4,
  input  logic [INST_W-1:0] in_inst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc4,
  output logic [INST_W-1:0] out_inst,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  occ_state_t        r_state;
  occ_state_t        w_state_next;
  logic              r_in_ready;
  logic              w_accept;
  logic              w_consume;
  logic              w_main_load;
  logic              w_main_clear;
  logic              w_main_from_skid;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic              w_main_valid;
  logic              w_skid_valid;
  logic [PC_W-1:0]   w_skid_pc4;
  logic [INST_W-1:0] w_skid_inst;
  logic [PC_W-1:0]   w_main_pc4_in;
  logic [INST_W-1:0] w_main_inst_in;

  assign w_accept  = in_valid & r_in_ready;
  assign w_consume = w_main_valid & out_ready;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != ST_SKID);
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_main_load      = 1'b0;
    w_main_clear     = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      w_state_next = ST_EMPTY;
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_next = ST_MAIN;
            w_main_load  = 1'b1;
          end
        end
        ST_MAIN: begin
          if (w_accept && w_consume) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_state_next = ST_SKID;
            w_skid_load  = 1'b1;
          end else if (w_consume) begin
            w_state_next = ST_EMPTY;
            w_main_clear = 1'b1;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so only the drain of main can happen.
          if (w_consume) begin
            w_state_next     = ST_MAIN;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
          end
        end
        default: begin
          w_state_next = ST_EMPTY;
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign w_main_pc4_in  = w_main_from_skid ? w_skid_pc4  : in_pc4;
  assign w_main_inst_in = w_main_from_skid ? w_skid_inst : in_inst;

  pipe_skid_entry #(.PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP_INST)) u_main (
    .clock   (clock),
    .resetn  (resetn),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_pc4   (w_main_pc4_in),
    .i_inst  (w_main_inst_in),
    .o_valid (w_main_valid),
    .o_pc4   (out_pc4),
    .o_inst  (out_inst)
  );

  pipe_skid_entry #(.PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP_INST)) u_skid (
    .clock   (clock),
    .resetn  (resetn),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_pc4   (in_pc4),
    .i_inst  (in_inst),
    .o_valid (w_skid_valid),
    .o_pc4   (w_skid_pc4),
    .o_inst  (w_skid_inst)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = w_main_valid;
  assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (!flush) begin
      if (w_main_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (!w_main_valid && (r_bubble_cnt != 32'hFFFF_FFFF))
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
